hash_job_ctrl: RTL and testbench

Job sequencer between the control/status register file and one hashing core. Takes single-cycle command pulses (start, abort, status-clear) from self-clearing control bits, walks a nonce range by issuing one core operation per nonce, and stops on first hit, range end or abort. Reports sticky status bits and a completion interrupt pulse back to the register file.

---
 rtl/hash_job_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hash_job_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hash_job_ctrl
// Brief    : Walks a nonce range on one hashing core; stops on hit/end/abort.
// Revision : 1.0
// ============================================================================
module hash_job_ctrl #(
    parameter int NONCE_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               clr_status_i,
    input  logic [NONCE_W-1:0] nonce_start_i,
    input  logic [NONCE_W-1:0] nonce_end_i,
    input  logic               core_ready_i,
    output logic               core_start_o,
    output logic [NONCE_W-1:0] core_nonce_o,
    input  logic               core_done_i,
    input  logic               core_hit_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               found_o,
    output logic               aborted_o,
    output logic [NONCE_W-1:0] found_nonce_o,
    output logic [NONCE_W-1:0] cur_nonce_o,
    output logic [CNT_W-1:0]   op_count_o,
    output logic               irq_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t               state_q, state_d;
    logic [NONCE_W-1:0]   cur_nonce_q, cur_nonce_d;
    logic [NONCE_W-1:0]   end_nonce_q, end_nonce_d;
    logic [NONCE_W-1:0]   found_nonce_q, found_nonce_d;
    logic [CNT_W-1:0]     op_count_q, op_count_d;
    logic                 done_q, done_d;
    logic                 found_q, found_d;
    logic                 aborted_q, aborted_d;
    logic                 irq_q, irq_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            cur_nonce_q   <= '0;
            end_nonce_q   <= '0;
            found_nonce_q <= '0;
            op_count_q    <= '0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            aborted_q     <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_nonce_q   <= cur_nonce_d;
            end_nonce_q   <= end_nonce_d;
            found_nonce_q <= found_nonce_d;
            op_count_q    <= op_count_d;
            done_q        <= done_d;
            found_q       <= found_d;
            aborted_q     <= aborted_d;
            irq_q         <= irq_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_nonce_d   = cur_nonce_q;
        end_nonce_d   = end_nonce_q;
        found_nonce_d = found_nonce_q;
        op_count_d    = op_count_q;
        done_d        = done_q;
        found_d       = found_q;
        aborted_d     = aborted_q;
        irq_d         = 1'b0;

        // Clear first so that a flag set by a same-cycle job end overrides it.
        if (clr_status_i) begin
            done_d    = 1'b0;
            found_d   = 1'b0;
            aborted_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d     = S_ISSUE;
                    cur_nonce_d = nonce_start_i;
                    end_nonce_d = nonce_end_i;
                    op_count_d  = '0;
                    done_d      = 1'b0;
                    found_d     = 1'b0;
                    aborted_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (abort_i) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    irq_d     = 1'b1;
                end else if (core_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Abort outranks a coincident completion: the result is discarded.
                if (abort_i) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    irq_d     = 1'b1;
                end else if (core_done_i) begin
                    if (op_count_q != c_CNT_MAX) begin
                        op_count_d = op_count_q + CNT_W'(1);
                    end
                    if (core_hit_i) begin
                        state_d       = S_IDLE;
                        done_d        = 1'b1;
                        found_d       = 1'b1;
                        found_nonce_d = cur_nonce_q;
                        irq_d         = 1'b1;
                    end else if (cur_nonce_q == end_nonce_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        cur_nonce_d = cur_nonce_q + NONCE_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign core_start_o  = (state_q == S_ISSUE) && core_ready_i;
    assign core_nonce_o  = cur_nonce_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign found_o       = found_q;
    assign aborted_o     = aborted_q;
    assign found_nonce_o = found_nonce_q;
    assign cur_nonce_o   = cur_nonce_q;
    assign op_count_o    = op_count_q;
    assign irq_o         = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_job_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_job_ctrl
// Brief    : Scoreboard bench for hash_job_ctrl with a behavioural core model.
// Revision : 1.0
// ============================================================================
module tb_hash_job_ctrl;

    typedef struct packed {
        logic [3:0]  flags;   // {busy, done, found, aborted}
        logic [31:0] fnonce;
        logic [31:0] cnt;
    } end_rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, tb_abort, tb_clr, hold_ready;
    logic        model_abort, model_clr;
    logic [31:0] nonce_start, nonce_end;
    logic        core_done, core_hit;
    wire         core_start_o, busy_o, done_o, found_o, aborted_o, irq_o;
    wire  [31:0] core_nonce_o, found_nonce_o, cur_nonce_o, op_count_o;

    int          n_checks = 0;
    int          n_fails  = 0;

    logic [31:0] exp_nonce[$];
    end_rec_t    exp_end[$];

    int          lat, countdown, stale_cnt, m_ops, abort_at_op, clr_at_op;
    bit          hit_en, stale_en, irq_prev;
    logic [31:0] hit_nonce, m_nonce;

    always #5 clk = ~clk;

    hash_job_ctrl #(.NONCE_W(32), .CNT_W(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .abort_i       (tb_abort | model_abort),
        .clr_status_i  (tb_clr | model_clr),
        .nonce_start_i (nonce_start),
        .nonce_end_i   (nonce_end),
        .core_ready_i  (~hold_ready),
        .core_start_o  (core_start_o),
        .core_nonce_o  (core_nonce_o),
        .core_done_i   (core_done),
        .core_hit_i    (core_hit),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .found_o       (found_o),
        .aborted_o     (aborted_o),
        .found_nonce_o (found_nonce_o),
        .cur_nonce_o   (cur_nonce_o),
        .op_count_o    (op_count_o),
        .irq_o         (irq_o)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] e, input logic with_abort);
        nonce_start = s;
        nonce_end   = e;
        start       = 1'b1;
        tb_abort    = with_abort;
        tick(1);
        start    = 1'b0;
        tb_abort = 1'b0;
    endtask

    task automatic pulse_clr();
        tb_clr = 1'b1;
        tick(1);
        tb_clr = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy_o && cyc < 500) begin
            tick(1);
            cyc++;
        end
        chk("job_ends_in_budget", {63'd0, busy_o}, 64'd0);
        tick(2);
        chk("all_issues_seen", exp_nonce.size(), 0);
        chk("all_ends_seen", exp_end.size(), 0);
    endtask

    function automatic end_rec_t mk_end(input logic found, input logic aborted,
                                        input logic [31:0] fn, input logic [31:0] cnt);
        end_rec_t r;
        r.flags  = {1'b0, 1'b1, found, aborted};
        r.fnonce = fn;
        r.cnt    = cnt;
        return r;
    endfunction

    // Core: completes LAT cycles after issue; may inject abort/clear with a chosen completion.
    task automatic core_model();
        logic        s;
        logic [31:0] n;
        forever begin
            @(negedge clk);
            s = core_start_o;
            n = core_nonce_o;
            core_done   = 1'b0;
            core_hit    = 1'b0;
            model_abort = 1'b0;
            model_clr   = 1'b0;
            if (!busy_o) m_ops = 0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    m_ops++;
                    core_done = 1'b1;
                    core_hit  = hit_en && (m_nonce == hit_nonce);
                    if (m_ops == abort_at_op) begin
                        model_abort = 1'b1;
                        if (stale_en) stale_cnt = 3;
                    end
                    if (m_ops == clr_at_op) model_clr = 1'b1;
                end
            end else if (stale_cnt > 0) begin
                stale_cnt--;
                if (stale_cnt == 0) begin
                    core_done = 1'b1;
                    core_hit  = 1'b1;
                end
            end
            if (s) begin
                countdown = lat;
                m_nonce   = n;
            end
        end
    endtask

    task automatic monitor();
        end_rec_t e;
        forever begin
            @(negedge clk);
            if (core_start_o) begin
                chk("issue_expected", {63'd0, exp_nonce.size() != 0}, 64'd1);
                if (exp_nonce.size() != 0) chk("core_nonce", core_nonce_o, exp_nonce.pop_front());
            end
            if (irq_o) begin
                chk("irq_single_pulse", {63'd0, irq_prev}, 64'd0);
                chk("irq_expected", {63'd0, exp_end.size() != 0}, 64'd1);
                if (exp_end.size() != 0) begin
                    e = exp_end.pop_front();
                    chk("end_flags", {60'd0, busy_o, done_o, found_o, aborted_o}, {60'd0, e.flags});
                    chk("end_found_nonce", found_nonce_o, e.fnonce);
                    chk("end_op_count", op_count_o, e.cnt);
                end
            end
            irq_prev = irq_o;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tb_abort = 1'b0; tb_clr = 1'b0; hold_ready = 1'b0;
        model_abort = 1'b0; model_clr = 1'b0; core_done = 1'b0; core_hit = 1'b0;
        nonce_start = '0; nonce_end = '0;
        lat = 3; countdown = 0; stale_cnt = 0; m_ops = 0; abort_at_op = 0; clr_at_op = 0;
        hit_en = 1'b0; stale_en = 1'b0; irq_prev = 1'b0; hit_nonce = '0; m_nonce = '0;

        fork
            core_model();
            monitor();
        join_none

        // Reset state
        tick(3);
        chk("rst_flags", {58'd0, busy_o, done_o, found_o, aborted_o, irq_o, core_start_o}, 64'd0);
        chk("rst_counts", {cur_nonce_o, op_count_o}, 64'd0);
        chk("rst_found_nonce", found_nonce_o, 64'd0);
        rst_n = 1'b1;
        tick(1);

        // Plain range, no hit
        for (int i = 'h10; i <= 'h13; i++) exp_nonce.push_back(32'(i));
        exp_end.push_back(mk_end(1'b0, 1'b0, 32'h0, 32'd4));
        pulse_start(32'h10, 32'h13, 1'b0);
        chk("start_latency", {62'd0, busy_o, core_start_o}, 64'd3);
        wait_idle();
        chk("t1_op_count", op_count_o, 64'd4);

        // Hit on 0x105 stops the walk
        lat = 1; hit_en = 1'b1; hit_nonce = 32'h105;
        for (int i = 'h100; i <= 'h105; i++) exp_nonce.push_back(32'(i));
        exp_end.push_back(mk_end(1'b1, 1'b0, 32'h105, 32'd6));
        pulse_start(32'h100, 32'h1FF, 1'b0);
        wait_idle();
        hit_en = 1'b0;

        // Wrap-around range
        lat = 2;
        exp_nonce.push_back(32'hFFFF_FFFE);
        exp_nonce.push_back(32'hFFFF_FFFF);
        exp_nonce.push_back(32'h0);
        exp_nonce.push_back(32'h1);
        exp_end.push_back(mk_end(1'b0, 1'b0, 32'h105, 32'd4));
        pulse_start(32'hFFFF_FFFE, 32'h1, 1'b0);
        wait_idle();

        // Abort coincides with a hit completion on op 2; stale completion follows
        lat = 3; hit_en = 1'b1; hit_nonce = 32'h21; abort_at_op = 2; stale_en = 1'b1;
        exp_nonce.push_back(32'h20);
        exp_nonce.push_back(32'h21);
        exp_end.push_back(mk_end(1'b0, 1'b1, 32'h105, 32'd1));
        pulse_start(32'h20, 32'h2F, 1'b0);
        wait_idle();
        tick(4);
        chk("t4_flags_after_stale", {60'd0, busy_o, done_o, found_o, aborted_o}, 64'b0101);
        chk("t4_op_count_after_stale", op_count_o, 64'd1);
        pulse_clr();
        chk("t4_clr_flags", {61'd0, done_o, found_o, aborted_o}, 64'd0);
        hit_en = 1'b0; abort_at_op = 0; stale_en = 1'b0;
        exp_nonce.push_back(32'h30);
        exp_nonce.push_back(32'h31);
        exp_end.push_back(mk_end(1'b0, 1'b0, 32'h105, 32'd2));
        pulse_start(32'h30, 32'h31, 1'b0);
        wait_idle();

        // Start while busy ignored; clear coinciding with job end loses
        hit_en = 1'b1; hit_nonce = 32'h42; clr_at_op = 3;
        for (int i = 'h40; i <= 'h42; i++) exp_nonce.push_back(32'(i));
        exp_end.push_back(mk_end(1'b1, 1'b0, 32'h42, 32'd3));
        pulse_start(32'h40, 32'h42, 1'b0);
        tick(2);
        pulse_start(32'h99, 32'h99, 1'b0);
        wait_idle();
        hit_en = 1'b0; clr_at_op = 0;
        chk("t5_flags_after_clr_race", {61'd0, done_o, found_o, aborted_o}, 64'b110);
        pulse_start(32'h77, 32'h77, 1'b1);
        tick(3);
        chk("t5_start_abort_idle", {60'd0, busy_o, done_o, found_o, aborted_o}, 64'b0110);
        chk("t5_state_kept", {cur_nonce_o, op_count_o}, {32'h42, 32'd3});
        pulse_clr();
        chk("t5_clr_flags", {61'd0, done_o, found_o, aborted_o}, 64'd0);
        chk("t5_clr_keeps_regs", {found_nonce_o, op_count_o}, {32'h42, 32'd3});

        // Reset in WAIT abandons the job silently
        lat = 3;
        exp_nonce.push_back(32'h50);
        pulse_start(32'h50, 32'h5F, 1'b0);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("t6_rst_flags", {58'd0, busy_o, done_o, found_o, aborted_o, irq_o, core_start_o}, 64'd0);
        chk("t6_rst_regs", {cur_nonce_o, op_count_o}, 64'd0);
        chk("t6_rst_found_nonce", found_nonce_o, 64'd0);
        tick(6);
        chk("t6_issues_seen", exp_nonce.size(), 0);

        // Core not ready: job holds in ISSUE
        hold_ready = 1'b1;
        exp_nonce.push_back(32'h60);
        exp_end.push_back(mk_end(1'b0, 1'b0, 32'h0, 32'd1));
        pulse_start(32'h60, 32'h60, 1'b0);
        tick(3);
        chk("t7_busy_no_issue", {62'd0, busy_o, core_start_o}, 64'b10);
        hold_ready = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
